// File: rtl/addsub_sequencer_pkg.sv
// Shared encodings for the nibble-serial add/subtract sequencer.
package addsub_sequencer_pkg;

  // Width of one datapath slice
  localparam int NIBBLE_W = 4;

  // Operation encoding; OP_SUB doubles as the initial carry-in for a + ~b + 1
  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // Controller states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/addsub_sequencer_nibble_addsub.sv
// Combinational 4-bit adder/subtractor slice: a + (b ^ {4{sub}}) + cin.
// Also exposes the carry into the MSB so signed overflow can be formed.
module nibble_addsub
  import addsub_sequencer_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                sub,
  input  logic                cin,
  output logic [NIBBLE_W-1:0] sum,
  output logic                cout,
  output logic                c3
);

  logic [NIBBLE_W-1:0] b_eff;
  logic [NIBBLE_W-1:0] low_sum;

  // Add the lower bits first to get the carry into the MSB, then finish the MSB by hand
  always_comb begin
    b_eff   = b ^ {NIBBLE_W{sub}};
    low_sum = {1'b0, a[NIBBLE_W-2:0]} + {1'b0, b_eff[NIBBLE_W-2:0]}
              + {{(NIBBLE_W-1){1'b0}}, cin};
    c3      = low_sum[NIBBLE_W-1];
    sum     = {a[NIBBLE_W-1] ^ b_eff[NIBBLE_W-1] ^ c3, low_sum[NIBBLE_W-2:0]};
    cout    = (a[NIBBLE_W-1] & b_eff[NIBBLE_W-1]) |
              (c3 & (a[NIBBLE_W-1] ^ b_eff[NIBBLE_W-1]));
  end

endmodule

// File: rtl/addsub_sequencer.sv
// Wide add/subtract done one nibble per clock through a single shared
// 4-bit slice, LSB nibble first, with the carry held in a register between
// slices. Start/busy/done handshake; back-to-back starts are taken from DONE.
module addsub_sequencer
  import addsub_sequencer_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic                          op,
  input  logic [NIBBLE_W*NIBBLES-1:0]   a,
  input  logic [NIBBLE_W*NIBBLES-1:0]   b,
  output logic                          busy,
  output logic                          done,
  output logic [NIBBLE_W*NIBBLES-1:0]   result,
  output logic                          carry_out,
  output logic                          overflow
);

  localparam int W     = NIBBLE_W * NIBBLES;
  localparam int CNT_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NIBBLES - 1);

  state_t              state;
  state_t              state_next;
  logic [W-1:0]        a_reg;
  logic [W-1:0]        b_reg;
  logic                op_reg;
  logic [CNT_W-1:0]    nib_idx;
  logic                carry_reg;
  logic                accept;
  logic                last_slice;
  logic [NIBBLE_W-1:0] a_slice;
  logic [NIBBLE_W-1:0] b_slice;
  logic [NIBBLE_W-1:0] sum_slice;
  logic                slice_cout;
  logic                slice_c3;

  // A request is taken whenever the unit is not mid-sequence
  assign accept     = start && (state != ST_RUN);
  assign last_slice = (nib_idx == LAST_IDX);

  // Pick the operand nibbles addressed by the slice counter
  always_comb begin
    a_slice = '0;
    b_slice = '0;
    for (int i = 0; i < NIBBLES; i++) begin
      if (nib_idx == CNT_W'(i)) begin
        a_slice = a_reg[i*NIBBLE_W +: NIBBLE_W];
        b_slice = b_reg[i*NIBBLE_W +: NIBBLE_W];
      end
    end
  end

  nibble_addsub u_slice (
    .a    (a_slice),
    .b    (b_slice),
    .sub  (op_reg),
    .cin  (carry_reg),
    .sum  (sum_slice),
    .cout (slice_cout),
    .c3   (slice_c3)
  );

  // State register; reset abandons any operation in flight
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and handshake outputs, both decoded straight from the state
  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) state_next = ST_RUN;
      end
      ST_RUN: begin
        busy = 1'b1;
        if (last_slice) state_next = ST_DONE;
      end
      ST_DONE: begin
        done       = 1'b1;
        state_next = start ? ST_RUN : ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Operand capture on accept, then one slice of the result per RUN cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_reg     <= '0;
      b_reg     <= '0;
      op_reg    <= OP_ADD;
      nib_idx   <= '0;
      carry_reg <= 1'b0;
      result    <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
    end else if (accept) begin
      a_reg     <= a;
      b_reg     <= b;
      op_reg    <= op;
      nib_idx   <= '0;
      carry_reg <= op;
      result    <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
    end else if (state == ST_RUN) begin
      for (int i = 0; i < NIBBLES; i++) begin
        if (nib_idx == CNT_W'(i)) begin
          result[i*NIBBLE_W +: NIBBLE_W] <= sum_slice;
        end
      end
      carry_reg <= slice_cout;
      if (last_slice) begin
        nib_idx   <= '0;
        carry_out <= slice_cout ^ op_reg;
        overflow  <= slice_cout ^ slice_c3;
      end else begin
        nib_idx <= nib_idx + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_addsub_sequencer.sv
// Scoreboard bench for addsub_sequencer: expected results are pushed on
// accept and popped by a monitor whenever done is seen.
module tb_addsub_sequencer;
  import addsub_sequencer_pkg::*;

  localparam int NIBBLES = 4;
  localparam int W       = 4 * NIBBLES;

  typedef struct {
    logic [W-1:0] res;
    logic         cy;
    logic         ov;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic         op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         carry_out;
  logic         overflow;

  exp_t exp_q[$];
  exp_t mon_e;
  int   total = 0;
  int   bad   = 0;
  int   cyc;

  addsub_sequencer #(.NIBBLES(NIBBLES)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .op        (op),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .carry_out (carry_out),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  // Reference: plain integer arithmetic on the full operands
  function automatic exp_t model(input logic op_i, input logic [W-1:0] a_i, input logic [W-1:0] b_i);
    exp_t        e;
    logic [W:0]  full;
    if (op_i == OP_ADD) begin
      full = {1'b0, a_i} + {1'b0, b_i};
      e.cy = full[W];
      e.ov = (a_i[W-1] == b_i[W-1]) && (full[W-1] != a_i[W-1]);
    end else begin
      full = {1'b0, a_i} - {1'b0, b_i};
      e.cy = (a_i < b_i);
      e.ov = (a_i[W-1] != b_i[W-1]) && (full[W-1] != a_i[W-1]);
    end
    e.res = full[W-1:0];
    return e;
  endfunction

  task automatic checkOutput(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Present a request and let it be taken on the next rising edge
  task automatic applyStimulus(input logic op_i, input logic [W-1:0] a_i, input logic [W-1:0] b_i,
                               input bit push, input bit keep_start);
    start = 1'b1;
    op    = op_i;
    a     = a_i;
    b     = b_i;
    @(posedge clk);
    if (push) exp_q.push_back(model(op_i, a_i, b_i));
    #1;
    checkOutput("busy_after_accept", busy, 1);
    checkOutput("done_after_accept", done, 0);
    if (!keep_start) start = 1'b0;
    a  = W'($urandom);
    b  = W'($urandom);
    op = 1'($urandom);
  endtask

  // Count rising edges until done appears, bounded
  task automatic waitDone(output int cycles);
    cycles = 0;
    for (int i = 0; i < 4 * NIBBLES + 8; i++) begin
      @(posedge clk);
      #1;
      cycles++;
      if (done === 1'b1) begin
        checkOutput("busy_at_done", busy, 0);
        return;
      end
    end
    total++;
    bad++;
    $display("[TB] FAIL done_timeout actual=none expected=done within %0d cycles", 4 * NIBBLES + 8);
    cycles = -1;
  endtask

  // Monitor: every done pulse must match the oldest outstanding request
  always @(negedge clk) begin
    if (reset === 1'b0 && done === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL unexpected_done actual=done expected=no pending request");
      end else begin
        mon_e = exp_q.pop_front();
        checkOutput("result", result, mon_e.res);
        checkOutput("carry_out", carry_out, mon_e.cy);
        checkOutput("overflow", overflow, mon_e.ov);
      end
    end
  end

  initial begin
    reset = 1'b1;
    start = 1'b0;
    op    = OP_ADD;
    a     = '0;
    b     = '0;
    repeat (3) @(negedge clk);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_done", done, 0);
    checkOutput("reset_result", result, 0);
    checkOutput("reset_carry", carry_out, 0);
    checkOutput("reset_ovf", overflow, 0);
    reset = 1'b0;
    @(negedge clk);

    $display("[TB] directed add 0x1234+0x0FFF");
    applyStimulus(OP_ADD, 16'h1234, 16'h0FFF, 1, 0);
    waitDone(cyc);
    checkOutput("latency", cyc, NIBBLES);
    checkOutput("add_1234", result, 16'h2233);
    @(negedge clk);

    $display("[TB] directed subtract/overflow corners");
    applyStimulus(OP_SUB, 16'h0000, 16'h0001, 1, 0);
    waitDone(cyc);
    checkOutput("sub_borrow", carry_out, 1);
    applyStimulus(OP_SUB, 16'h8000, 16'h0001, 1, 0);
    waitDone(cyc);
    checkOutput("sub_ovf", overflow, 1);
    applyStimulus(OP_ADD, 16'h7FFF, 16'h0001, 1, 0);
    waitDone(cyc);
    checkOutput("add_ovf_res", result, 16'h8000);

    $display("[TB] start pulse during RUN is ignored");
    applyStimulus(OP_ADD, 16'hFFFF, 16'h0001, 1, 0);
    @(posedge clk);
    #1;
    start = 1'b1;
    a     = 16'h1111;
    b     = 16'h2222;
    op    = OP_SUB;
    @(posedge clk);
    #1;
    start = 1'b0;
    waitDone(cyc);
    checkOutput("latency_ignored_start", cyc, NIBBLES - 2);
    checkOutput("wrap_res", result, 16'h0000);
    checkOutput("wrap_carry", carry_out, 1);
    repeat (3) begin
      @(posedge clk);
      #1;
      checkOutput("no_extra_done", done, 0);
    end

    $display("[TB] reset in the middle of a run");
    applyStimulus(OP_SUB, 16'h5000, 16'h1000, 0, 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    checkOutput("midreset_busy", busy, 0);
    checkOutput("midreset_done", done, 0);
    checkOutput("midreset_result", result, 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    applyStimulus(OP_ADD, 16'h0001, 16'h0002, 1, 0);
    waitDone(cyc);
    checkOutput("post_reset_add", result, 16'h0003);

    $display("[TB] back-to-back with start held high");
    @(negedge clk);
    applyStimulus(OP_ADD, 16'h0010, 16'h0020, 1, 1);
    waitDone(cyc);
    checkOutput("b2b_first_latency", cyc, NIBBLES);
    applyStimulus(OP_SUB, 16'h0030, 16'h0030, 1, 1);
    #0 start = 1'b1;
    waitDone(cyc);
    start = 1'b0;
    checkOutput("b2b_second_latency", cyc, NIBBLES);
    checkOutput("b2b_second_res", result, 16'h0000);
    checkOutput("b2b_second_borrow", carry_out, 0);
    @(posedge clk);
    #1;
    checkOutput("b2b_idle_after", busy, 0);

    $display("[TB] randomized operations");
    for (int i = 0; i < 40; i++) begin
      logic keep;
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      keep = 1'($urandom_range(0, 1));
      ra   = W'($urandom);
      rb   = W'($urandom);
      if ($urandom_range(0, 3) == 0) rb = ra;
      applyStimulus(1'($urandom), ra, rb, 1, keep);
      waitDone(cyc);
      checkOutput("rand_latency", cyc, NIBBLES);
      if (!keep) begin
        start = 1'b0;
        repeat ($urandom_range(0, 2)) @(posedge clk);
        #1;
      end
    end
    start = 1'b0;

    repeat (NIBBLES + 3) @(posedge clk);
    #1;
    checkOutput("queue_drained", W'(exp_q.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/addsub_sequencer.md
Name: addsub_sequencer

Overview:
Multi-cycle controller that performs wide add/subtract (NIBBLES×4 bits) by sequencing a single shared 4-bit adder/subtractor datapath, one nibble per clock, LSB nibble first, with a registered carry/borrow chain. It sits between the arithmetic-unit front end (operand/op source) and the 4-bit nibble datapath used by the Sum/Substraction blocks. Handshake is start/busy/done.

Parameters:
NIBBLES, 4, number of 4-bit slices per operand; operand width W = 4*NIBBLES; minimum 1.

Ports:
clk  input  1  system clock, rising-edge.
reset  input  1  asynchronous, active-high reset.
start  input  1  request; sampled on rising clk edge, accepted only in IDLE or DONE state.
op  input  1  0 = add (a+b), 1 = subtract (a-b); latched on accept.
a  input  W  first operand; latched on accept.
b  input  W  second operand; latched on accept.
busy  output  1  high while state = RUN.
done  output  1  high for exactly one cycle (state = DONE) when result is valid.
result  output  W  sum/difference; registered.
carry_out  output  1  add: final carry; sub: borrow (inverse of final carry).
overflow  output  1  two's-complement signed overflow of the W-bit operation.

Behaviour:
- Reset (async, any time incl. mid-run): state IDLE, nibble counter 0, carry reg 0, result 0, carry_out 0, overflow 0, busy 0, done 0. Any operation in progress is discarded.
- States: IDLE, RUN, DONE. IDLE --start--> RUN; RUN --last nibble--> DONE; DONE --start--> RUN, else IDLE.
- Accept (edge E0, start=1 in IDLE/DONE): latch a, b, op; counter := 0; carry reg := op (subtract = a + ~b + 1); result := 0; carry_out, overflow := 0.
- RUN, edge Ek (k = 1..NIBBLES), slice i = k-1: {c, s} = a[4i+3:4i] + (b[4i+3:4i] XOR {4{op}}) + carry reg; result[4i+3:4i] := s; carry reg := c; counter++.
- At edge E_NIBBLES: also carry_out := c XOR op; overflow := c XOR c3 (c3 = carry into bit 3 of last slice); state := DONE.
- done high in the single cycle following E_NIBBLES; busy high from E0 until E_NIBBLES. Latency start-edge to done = NIBBLES cycles; throughput one op per NIBBLES+1 cycles.
- result/carry_out/overflow hold their values from DONE until the next accept; partial result visible during RUN is not guaranteed meaningful.
- start while busy: ignored, no effect on latched operands or sequence. Operand/op changes after accept: no effect.
- start in DONE: accepted same as IDLE (back-to-back), done falls, busy rises next cycle.
- Arithmetic is modulo 2^W; no saturation.

Decomposition:
- Shared package/header: op encoding constants (OP_ADD=0, OP_SUB=1), state encodings (IDLE/RUN/DONE), NIBBLE_W=4.
- One sub-module: nibble_addsub — combinational 4-bit a + (b XOR {4{sub}}) + cin, outputs sum[3:0], cout, c3 (carry into MSB). Sequencer instantiates exactly one and time-multiplexes it.

Test Plan:
- add a=0x1234 b=0x0FFF (NIBBLES=4) -> done 4 cycles after start edge, result 0x2233, carry_out 0, overflow 0, busy high 4 cycles.
- sub a=0x0000 b=0x0001 -> result 0xFFFF, carry_out(borrow) 1, overflow 0.
- sub a=0x8000 b=0x0001 -> result 0x7FFF, carry_out 0, overflow 1; add a=0x7FFF b=0x0001 -> 0x8000, carry 0, overflow 1.
- add a=0xFFFF b=0x0001 -> result 0x0000, carry_out 1, overflow 0; change a/b and pulse start during RUN -> result unchanged, no extra done.
- assert reset after 2 RUN cycles of sub 0x5000-0x1000 -> immediately busy 0, done 0, result 0, state IDLE; next add 0x0001+0x0002 -> 0x0003.
- start held high continuously with add 0x0010+0x0020 then sub 0x0030-0x0030 -> done pulses every 5 cycles, results 0x0030 then 0x0000 (borrow 0).
